// File: rtl/scope_pkg.sv
// -----------------------------------------------------------------------------
// scope_pkg
// Shared types and helpers for the multi-channel scope capture engine.
//   scope_state_t : capture sequencer states
//   trig_mode_t   : trigger source / edge selection (encoding matches the
//                   2-bit trig_mode input)
//   chan_w()      : width of a channel-select field for a given channel count
// -----------------------------------------------------------------------------
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POST,
        DONE
    } scope_state_t;

    typedef enum logic [1:0] {
        RISE,
        FALL,
        EXT,
        AUTO
    } trig_mode_t;

    localparam int unsigned NCH_DEFAULT = 4;
    localparam int unsigned CHW_DEFAULT = $clog2(NCH_DEFAULT);

    // A single-channel build still needs a 1-bit select port.
    function automatic int unsigned chan_w(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// -----------------------------------------------------------------------------
// scope_trig_detect
// Trigger qualifier for one selected channel. Owns the previous-sample
// register used for edge detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : arm pulse; invalidates the previous sample
//   valid      : an admitted sample is present on 'sample' this cycle
//   sample     : current sample of the trigger channel (signed)
//   level      : signed threshold
//   mode       : RISE / FALL / EXT / AUTO
//   ext        : external trigger level, qualified by valid
//   trig       : combinational, high for the admitted sample that triggers
// -----------------------------------------------------------------------------
module scope_trig_detect
    import scope_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          valid,
    input  logic [DW-1:0] sample,
    input  logic [DW-1:0] level,
    input  trig_mode_t    mode,
    input  logic          ext,
    output logic          trig
);

    logic [DW-1:0] prev_q;
    logic          prev_vld_q;

    logic prev_below;
    logic cur_below;

    assign prev_below = $signed(prev_q) < $signed(level);
    assign cur_below  = $signed(sample) < $signed(level);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        trig = 1'b0;
        if (valid) begin
            case (mode)
                RISE:    trig = prev_vld_q && prev_below && !cur_below;
                FALL:    trig = prev_vld_q && !prev_below && cur_below;
                EXT:     trig = ext;
                AUTO:    trig = 1'b1;
                default: trig = 1'b0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (clear) begin
            // The first sample after arm has no valid predecessor.
            prev_vld_q <= 1'b0;
        end else if (valid) begin
            prev_q     <= sample;
            prev_vld_q <= 1'b1;
        end
    end

endmodule

// File: rtl/scope_capture_mc.sv
// -----------------------------------------------------------------------------
// scope_capture_mc
// Multi-channel triggered capture engine with programmable pre-trigger depth
// and circular-buffer readout. Single clock domain.
//
// Optional feature macro: SCOPE_DECIM_EN
//   When defined, adds the 8-bit 'decim' input; one sample is admitted per
//   decim+1 adc_valid strobes (counter cleared on arm). When undefined every
//   adc_valid sample is admitted.
//
// Ports:
//   clk, rst_n  : capture clock, asynchronous active-low reset
//   adc_data    : NCH packed samples, channel k at [k*DW +: DW]
//   adc_valid   : sample strobe, common to all channels
//   arm         : one-cycle pulse, (re)starts a capture
//   trig_mode   : 0 rising, 1 falling, 2 external, 3 auto
//   trig_chan   : channel compared against trig_level
//   trig_level  : signed threshold
//   trig_ext    : external trigger, sampled with admitted samples
//   pretrig     : samples kept before the trigger
//   decim       : (SCOPE_DECIM_EN only) decimation ratio minus one
//   rd_chan     : readout channel select
//   rd_addr     : readout index relative to the oldest captured sample
//   rd_data     : readout data, two clocks after rd_addr/rd_chan
//   busy        : capture in progress (PREFILL, WAIT_TRIG, POST)
//   done        : capture complete
//   trig_pos    : absolute buffer address of the trigger sample
// -----------------------------------------------------------------------------
module scope_capture_mc
    import scope_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int AW  = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH*DW-1:0]       adc_data,
    input  logic                    adc_valid,
    input  logic                    arm,
    input  logic [1:0]              trig_mode,
    input  logic [chan_w(NCH)-1:0]  trig_chan,
    input  logic [DW-1:0]           trig_level,
    input  logic                    trig_ext,
    input  logic [AW-1:0]           pretrig,
`ifdef SCOPE_DECIM_EN
    input  logic [7:0]              decim,
`endif
    input  logic [chan_w(NCH)-1:0]  rd_chan,
    input  logic [AW-1:0]           rd_addr,
    output logic [DW-1:0]           rd_data,
    output logic                    busy,
    output logic                    done,
    output logic [AW-1:0]           trig_pos
);

    localparam int CW = chan_w(NCH);
    localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] WP_ONE  = AW'(1);

    scope_state_t  state_q;
    logic [AW:0]   cnt_q;
    logic [AW-1:0] wp_q;
    logic [AW-1:0] trig_pos_q;
    logic [AW-1:0] pre_l_q;
    trig_mode_t    mode_l_q;
    logic [CW-1:0] chan_l_q;
    logic [DW-1:0] level_l_q;
    logic          busy_q;
    logic          done_q;

    logic          adm;
    logic          wr_en;
    logic          trig;
    logic [AW:0]   cnt_inc;
    logic [AW:0]   post_len;
    logic [AW-1:0] rd_phys;

    // ---------------------------------------------------------------- admit
`ifdef SCOPE_DECIM_EN
    logic [7:0] dcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
        end else if (arm) begin
            dcnt_q <= '0;
        end else if (adc_valid) begin
            // '>=' lets a mid-run decrease of decim recover immediately.
            dcnt_q <= (dcnt_q >= decim) ? 8'd0 : dcnt_q + 8'd1;
        end
    end

    assign adm = adc_valid && (dcnt_q == 8'd0);
`else
    assign adm = adc_valid;
`endif

    // ---------------------------------------------------------- trigger path
    logic [DW-1:0] chan_s [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_split
        assign chan_s[k] = adc_data[k*DW +: DW];
    end

    scope_trig_detect #(.DW(DW)) u_trig (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (arm),
        .valid  (adm),
        .sample (chan_s[chan_l_q]),
        .level  (level_l_q),
        .mode   (mode_l_q),
        .ext    (trig_ext),
        .trig   (trig)
    );

    // ------------------------------------------------------------ sequencer
    // pretrig is AW bits wide, so its largest value is already 2^AW-1 and
    // POST always has at least the trigger sample: no explicit clamp needed.
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign post_len = DEPTH - {1'b0, pre_l_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            trig_pos_q <= '0;
            pre_l_q    <= '0;
            mode_l_q   <= RISE;
            chan_l_q   <= '0;
            level_l_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (arm) begin
            // Arm restarts from any state; the arm cycle itself writes nothing.
            pre_l_q   <= pretrig;
            mode_l_q  <= trig_mode_t'(trig_mode);
            chan_l_q  <= trig_chan;
            level_l_q <= trig_level;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            state_q   <= (pretrig == '0) ? WAIT_TRIG : PREFILL;
        end else if (adm) begin
            case (state_q)
                PREFILL: begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == {1'b0, pre_l_q}) begin
                        state_q <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (trig) begin
                        // The trigger sample is written this cycle and is the
                        // first of the post-trigger samples.
                        trig_pos_q <= wp_q;
                        cnt_q      <= CNT_ONE;
                        if (post_len == CNT_ONE) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= POST;
                        end
                    end
                end
                POST: begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == post_len) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------- write side
    assign wr_en = adm && !arm &&
                   (state_q == PREFILL || state_q == WAIT_TRIG || state_q == POST);

    // The write pointer free-runs across captures; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
        end else if (wr_en) begin
            wp_q <= wp_q + WP_ONE;
        end
    end

    // ------------------------------------------------------------- buffers
    assign rd_phys = trig_pos_q - pre_l_q + rd_addr;

    logic [DW-1:0] ram_rd [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ram
        logic [DW-1:0] mem [2**AW];
        logic [DW-1:0] rd_q;

        // NOTE: the buffer and its read register have no reset so they map
        // onto block RAM; their contents after reset are undefined anyway.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wp_q] <= adc_data[k*DW +: DW];
            end
            rd_q <= mem[rd_phys];
        end

        assign ram_rd[k] = rd_q;
    end

    // Second read stage: channel mux after the RAM output register.
    logic [CW-1:0] rd_chan_q;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_chan_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_chan_q <= rd_chan;
            rd_data_q <= ram_rd[rd_chan_q];
        end
    end

    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign trig_pos = trig_pos_q;

endmodule

// File: tb/tb_scope_capture_mc.sv
// -----------------------------------------------------------------------------
// tb_scope_capture_mc
// Self-checking bench for scope_capture_mc (NCH=4, DW=16, AW=6). A reference
// model records the admitted samples of each capture, finds the trigger index
// from the trigger rules, and derives the captured window and trigger address
// arithmetically. Readout expectations are queued when a read is issued and
// consumed by an independent monitor when the read data emerges.
// -----------------------------------------------------------------------------
module tb_scope_capture_mc;
    import scope_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int AW  = 6;
    localparam int N   = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*DW-1:0] adc_data;
    logic              adc_valid;
    logic              arm;
    logic [1:0]        trig_mode;
    logic [1:0]        trig_chan;
    logic [DW-1:0]     trig_level;
    logic              trig_ext;
    logic [AW-1:0]     pretrig;
    logic [7:0]        decim = 8'd0;
    logic [1:0]        rd_chan;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              busy;
    logic              done;
    logic [AW-1:0]     trig_pos;

    always #5 clk = ~clk;

    scope_capture_mc #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .arm        (arm),
        .trig_mode  (trig_mode),
        .trig_chan  (trig_chan),
        .trig_level (trig_level),
        .trig_ext   (trig_ext),
        .pretrig    (pretrig),
`ifdef SCOPE_DECIM_EN
        .decim      (decim),
`endif
        .rd_chan    (rd_chan),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .trig_pos   (trig_pos)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    logic [NCH*DW-1:0] hist [$];   // admitted samples since the last arm
    int          m_p;
    int          m_chan;
    trig_mode_t  m_mode;
    logic signed [DW-1:0] m_level;
    int          m_trig_idx;
    int          m_base;           // writes before this capture started
    int          m_writes;         // total buffer writes since reset
    int          m_vcount;         // valid strobes since arm
    int          m_sc;             // stimulus sample counter since arm
    int          m_kind;
    bit          m_active;

    function automatic logic [NCH*DW-1:0] gen(input int kind, input int sc);
        logic [NCH*DW-1:0] r;
        int v;
        for (int k = 0; k < NCH; k++) begin
            v = (k == 0) ? (sc - 50) : (k * 1000 + sc);
            if (kind == 1 && k == 2) v = ((sc / 5) % 2 == 0) ? 200 : -200;
            if (kind == 2) v = int'($urandom);
            r[k*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    task automatic model_sample(input logic [NCH*DW-1:0] d, input bit ext);
        int idx;
        bit hit;
        logic signed [DW-1:0] cur, prv;
        if (!m_active) return;
        if ((m_vcount % (int'(decim) + 1)) != 0) begin
            m_vcount++;
            return;
        end
        m_vcount++;
        idx = hist.size();
        hist.push_back(d);
        m_writes++;
        if (m_trig_idx < 0 && idx >= m_p) begin
            cur = d[m_chan*DW +: DW];
            prv = (idx > 0) ? hist[idx-1][m_chan*DW +: DW] : '0;
            case (m_mode)
                RISE:    hit = (idx > 0) && (prv < m_level) && (cur >= m_level);
                FALL:    hit = (idx > 0) && (prv >= m_level) && (cur < m_level);
                EXT:     hit = ext;
                default: hit = 1'b1;
            endcase
            if (hit) m_trig_idx = idx;
        end
        if (m_trig_idx >= 0 && hist.size() == m_trig_idx + N - m_p) m_active = 0;
    endtask

    // ------------------------------------------------------------- drivers
    task automatic step(input bit v, input bit ext);
        logic [NCH*DW-1:0] d;
        @(negedge clk);
        arm       = 1'b0;
        adc_valid = v;
        trig_ext  = ext;
        // Scramble the trigger setup to show the armed values are held.
        trig_mode  = 2'($urandom);
        trig_chan  = 2'($urandom);
        trig_level = 16'($urandom);
        pretrig    = 6'($urandom);
        if (v) begin
            d = gen(m_kind, m_sc);
            m_sc++;
            adc_data = d;
            model_sample(d, ext);
        end
    endtask

    task automatic do_arm(input int p, input trig_mode_t mode, input int chan,
                          input int level, input int kind);
        @(negedge clk);
        arm        = 1'b1;
        adc_valid  = 1'b0;
        pretrig    = AW'(p);
        trig_mode  = mode;
        trig_chan  = 2'(chan);
        trig_level = DW'(level);
        hist.delete();
        m_p        = p;
        m_mode     = mode;
        m_chan     = chan;
        m_level    = DW'(level);
        m_trig_idx = -1;
        m_base     = m_writes;
        m_vcount   = 0;
        m_sc       = 0;
        m_kind     = kind;
        m_active   = 1;
    endtask

    // ext_at >= 0: external trigger high when that admitted index is offered;
    // -1: never; -2: random.
    task automatic feed(input int max_valid, input int ext_at);
        int fed = 0;
        int cyc = 0;
        bit v, e;
        while (m_active && fed < max_valid && cyc < max_valid * 4 + 100) begin
            v = ($urandom_range(0, 4) != 0);
            if (ext_at == -2) e = ($urandom_range(0, 9) == 0);
            else              e = (ext_at >= 0) && (hist.size() == ext_at);
            step(v, e);
            if (v) fed++;
            cyc++;
        end
    endtask

    task automatic status_check(input string tag);
        step(1'b0, 1'b0);
        if (!m_active) begin
            check({tag, " done"}, 32'(done), 32'd1);
            check({tag, " busy"}, 32'(busy), 32'd0);
            check({tag, " trig_pos"}, 32'(trig_pos), 32'((m_base + m_trig_idx) % N));
        end else begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done"}, 32'(done), 32'd0);
        end
    endtask

    // ------------------------------------------------------- scoreboard
    logic [DW-1:0] exp_q [$];
    bit            rd_issue = 1'b0;

    task automatic issue_read(input int ch, input int addr, input logic [DW-1:0] e);
        @(negedge clk);
        rd_chan  = 2'(ch);
        rd_addr  = AW'(addr);
        exp_q.push_back(e);
        rd_issue = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk);
        rd_issue = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic readout();
        int ch;
        if (m_active) return;
        for (int k = 0; k < N; k++) begin
            ch = $urandom_range(0, NCH - 1);
            issue_read(ch, k, hist[m_trig_idx - m_p + k][ch*DW +: DW]);
        end
        drain();
    endtask

    initial begin : monitor
        bit p1 = 1'b0;
        bit p2 = 1'b0;
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            p2 = p1;
            p1 = rd_issue;
            @(negedge clk);
            if (p2) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_data: data with no expectation queued, got 0x%0h", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------ sequence
    initial begin
        rst_n      = 1'b0;
        adc_data   = '0;
        adc_valid  = 1'b0;
        arm        = 1'b0;
        trig_mode  = '0;
        trig_chan  = '0;
        trig_level = '0;
        trig_ext   = 1'b0;
        pretrig    = '0;
        rd_chan    = '0;
        rd_addr    = '0;
        m_writes   = 0;
        m_active   = 0;
        m_kind     = 0;
        m_sc       = 0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset trig_pos", 32'(trig_pos), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;

        // Rising edge on a ramp: trigger at the sample equal to 100.
        do_arm(16, RISE, 0, 100, 0);
        feed(400, -1);
        status_check("rise");
        readout();
        issue_read(0, 16, DW'(100));
        issue_read(0, 0, DW'(84));
        drain();

        // Falling edge on a +-200 square wave on channel 2.
        do_arm(4, FALL, 2, 0, 1);
        feed(400, -1);
        status_check("fall");
        readout();
        issue_read(2, 4, DW'(-200));
        issue_read(0, 4, DW'(-45));
        issue_read(3, 4, DW'(3005));
        drain();

        // Auto trigger, no pre-trigger: busy spans exactly 64 samples.
        do_arm(0, AUTO, 1, 0, 0);
        feed(63, -1);
        status_check("auto 63");
        feed(1, -1);
        status_check("auto 64");
        readout();
        issue_read(1, 0, DW'(1000));
        drain();

        // Re-arm while waiting for a trigger that never comes.
        do_arm(5, RISE, 0, 32000, 0);
        feed(30, -1);
        status_check("wait");
        do_arm(10, RISE, 0, -30, 0);
        feed(400, -1);
        status_check("rearm");
        readout();

        // Reset in the middle of POST.
        do_arm(8, AUTO, 0, 0, 0);
        feed(20, -1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset trig_pos", 32'(trig_pos), 32'd0);
        check("midreset rd_data", 32'(rd_data), 32'd0);
        m_writes = 0;
        m_active = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // 200 samples in WAIT_TRIG, then external trigger: window wraps.
        do_arm(12, EXT, 0, 0, 0);
        feed(400, 12 + 200);
        status_check("wrap");
        readout();

        // Randomised captures.
        for (int i = 0; i < 6; i++) begin
            do_arm($urandom_range(0, N - 1), trig_mode_t'($urandom_range(0, 3)),
                   $urandom_range(0, NCH - 1), $urandom_range(0, 4000) - 2000, 2);
            feed(3000, -2);
            status_check("random");
            readout();
        end

`ifdef SCOPE_DECIM_EN
        // Decimation by 4 on a ramp.
        decim = 8'd3;
        do_arm(8, AUTO, 0, 0, 0);
        feed(800, -1);
        status_check("decim");
        readout();
        issue_read(0, 1, DW'(-46));
        issue_read(0, 2, DW'(-42));
        drain();
        decim = 8'd0;
`endif

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rd_queue: %0d expectations never matched", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
